song_sequencer: RTL and testbench

Upstream stage of the tone generator. Steps through a synchronous song ROM one slot at a time and presents each 8-bit note code (octave*12+note; 0 = rest) to the tone/display path on `fullnote`, with a `gate` that mutes the speaker.
Replaces the free-running address counter with a controllable player:
- play/pause and stop
- three tempos
- per-slot articulation gap
- loop or one-shot end-of-song.

---
 rtl/music_pkg.sv | 20 ++
 rtl/slot_timer.sv | 77 +++++++
 rtl/song_sequencer.sv | 150 +++++++++++++++
 tb/tb_song_sequencer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - shared state, tempo and note constants for the song player
package music_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_PLAY   = 2'd2,
      ST_PAUSED = 2'd3
   } seq_state_t;

   localparam logic [1:0] TEMPO_1X   = 2'b00;
   localparam logic [1:0] TEMPO_2X   = 2'b01;
   localparam logic [1:0] TEMPO_HALF = 2'b10;

   localparam logic [7:0] NOTE_REST = 8'd0;

   localparam int unsigned DEFAULT_SLOT_CYCLES = 4194304;
   localparam int unsigned DEFAULT_GAP_CYCLES  = 262144;

endpackage

// File: rtl/slot_timer.sv
// rtl/slot_timer.sv - tempo-scaled slot/gap lengths and the per-slot cycle counter
module slot_timer
   import music_pkg::*;
#(
   parameter int unsigned SLOT_CYCLES = DEFAULT_SLOT_CYCLES,
   parameter int unsigned GAP_CYCLES  = DEFAULT_GAP_CYCLES,
   parameter int unsigned CNT_W       = $clog2(2 * SLOT_CYCLES)
) (
   input  logic       clk,
   input  logic       RESET,
   input  logic [1:0] i_tempo,
   input  logic       i_clear,
   input  logic       i_en,
   output logic       o_at_gap,
   output logic       o_at_end
);

   localparam logic [CNT_W-1:0] END_1X   = CNT_W'(SLOT_CYCLES - 1);
   localparam logic [CNT_W-1:0] END_2X   = CNT_W'(SLOT_CYCLES / 2 - 1);
   localparam logic [CNT_W-1:0] END_HALF = CNT_W'(2 * SLOT_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_1X   = CNT_W'(GAP_CYCLES);
   localparam logic [CNT_W-1:0] GAP_2X   = CNT_W'(GAP_CYCLES / 2);
   localparam logic [CNT_W-1:0] GAP_HALF = CNT_W'(2 * GAP_CYCLES);

   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] r_end;
   logic [CNT_W-1:0] r_gap;
   logic [CNT_W-1:0] w_end_sel;
   logic [CNT_W-1:0] w_gap_sel;
   logic [CNT_W:0]   w_count_next;

   always_comb begin
      w_end_sel = END_1X;
      w_gap_sel = GAP_1X;
      case (i_tempo)
         TEMPO_2X: begin
            w_end_sel = END_2X;
            w_gap_sel = GAP_2X;
         end
         TEMPO_HALF: begin
            w_end_sel = END_HALF;
            w_gap_sel = GAP_HALF;
         end
         TEMPO_1X: begin
            w_end_sel = END_1X;
            w_gap_sel = GAP_1X;
         end
         default: begin
            w_end_sel = END_1X;
            w_gap_sel = GAP_1X;
         end
      endcase
   end

   // Lengths are captured together with the counter clear, so a tempo change
   // mid-slot only shows up on the following slot.
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         r_count <= '0;
         r_end   <= END_1X;
         r_gap   <= GAP_1X;
      end else if (i_clear) begin
         r_count <= '0;
         r_end   <= w_end_sel;
         r_gap   <= w_gap_sel;
      end else if (i_en) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   // Gap test looks at the next count so the registered gate lines up with
   // the first sounding cycle.
   assign w_count_next = {1'b0, r_count} + {{CNT_W{1'b0}}, 1'b1};
   assign o_at_gap     = (w_count_next >= {1'b0, r_gap});
   assign o_at_end     = (r_count == r_end);

endmodule

// File: rtl/song_sequencer.sv
// rtl/song_sequencer.sv - song ROM player with play/pause/stop, tempo, articulation gap and loop
module song_sequencer
   import music_pkg::*;
#(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned LAST_ADDR   = 240,
   parameter int unsigned SLOT_CYCLES = DEFAULT_SLOT_CYCLES,
   parameter int unsigned GAP_CYCLES  = DEFAULT_GAP_CYCLES
) (
   input  logic              clk,
   input  logic              RESET,
   input  logic              play,
   input  logic              stop,
   input  logic              loop_en,
   input  logic [1:0]        tempo,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [7:0]        rom_note,
   output logic [7:0]        fullnote,
   output logic              gate,
   output logic              busy,
   output logic              paused,
   output logic              song_done
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

   seq_state_t        r_state;
   logic              r_fetch_2nd;
   logic [ADDR_W-1:0] r_rom_addr;
   logic [7:0]        r_fullnote;
   logic              r_gate;
   logic              r_busy;
   logic              r_paused;
   logic              r_song_done;

   seq_state_t        w_state_next;
   logic              w_fetch_2nd_next;
   logic [ADDR_W-1:0] w_addr_next;
   logic [7:0]        w_note_next;
   logic              w_gate_next;
   logic              w_done_next;
   logic              w_tmr_clear;
   logic              w_tmr_en;
   logic              w_at_gap;
   logic              w_at_end;

   slot_timer #(
      .SLOT_CYCLES (SLOT_CYCLES),
      .GAP_CYCLES  (GAP_CYCLES)
   ) u_slot_timer (
      .clk      (clk),
      .RESET    (RESET),
      .i_tempo  (tempo),
      .i_clear  (w_tmr_clear),
      .i_en     (w_tmr_en),
      .o_at_gap (w_at_gap),
      .o_at_end (w_at_end)
   );

   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         r_state     <= ST_IDLE;
         r_fetch_2nd <= 1'b0;
         r_rom_addr  <= '0;
         r_fullnote  <= NOTE_REST;
         r_gate      <= 1'b0;
         r_busy      <= 1'b0;
         r_paused    <= 1'b0;
         r_song_done <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_fetch_2nd <= w_fetch_2nd_next;
         r_rom_addr  <= w_addr_next;
         r_fullnote  <= w_note_next;
         r_gate      <= w_gate_next;
         r_busy      <= (w_state_next != ST_IDLE);
         r_paused    <= (w_state_next == ST_PAUSED);
         r_song_done <= w_done_next;
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_fetch_2nd_next = 1'b0;
      w_addr_next      = r_rom_addr;
      w_note_next      = r_fullnote;
      w_gate_next      = 1'b0;
      w_done_next      = 1'b0;
      w_tmr_clear      = 1'b0;
      w_tmr_en         = 1'b0;
      if (stop) begin
         w_state_next = ST_IDLE;
         w_addr_next  = '0;
         w_note_next  = NOTE_REST;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_addr_next = '0;
               w_note_next = NOTE_REST;
               if (play) w_state_next = ST_FETCH;
            end
            // First cycle lets the ROM register the address, second captures its data.
            ST_FETCH: begin
               if (!r_fetch_2nd) begin
                  w_fetch_2nd_next = 1'b1;
               end else begin
                  w_note_next  = rom_note;
                  w_tmr_clear  = 1'b1;
                  w_state_next = ST_PLAY;
               end
            end
            ST_PLAY: begin
               if (play) begin
                  w_state_next = ST_PAUSED;
               end else if (w_at_end) begin
                  if (r_rom_addr != LAST) begin
                     w_addr_next  = r_rom_addr + ADDR_W'(1);
                     w_state_next = ST_FETCH;
                  end else if (loop_en) begin
                     w_addr_next  = '0;
                     w_state_next = ST_FETCH;
                  end else begin
                     w_done_next  = 1'b1;
                     w_addr_next  = '0;
                     w_note_next  = NOTE_REST;
                     w_state_next = ST_IDLE;
                  end
               end else begin
                  w_tmr_en    = 1'b1;
                  w_gate_next = w_at_gap && (r_fullnote != NOTE_REST);
               end
            end
            ST_PAUSED: begin
               if (play) w_state_next = ST_PLAY;
            end
            default: begin
               w_state_next = ST_IDLE;
            end
         endcase
      end
   end

   assign rom_addr  = r_rom_addr;
   assign fullnote  = r_fullnote;
   assign gate      = r_gate;
   assign busy      = r_busy;
   assign paused    = r_paused;
   assign song_done = r_song_done;

endmodule

// File: tb/tb_song_sequencer.sv
// tb/tb_song_sequencer.sv - randomized self-checking bench for song_sequencer against a slot-timeline model
`timescale 1ns/1ps
module tb_song_sequencer;

   localparam int SLOT = 16;
   localparam int GAP  = 4;
   localparam int LAST = 3;

   logic       clk     = 1'b0;
   logic       RESET   = 1'b1;
   logic       play    = 1'b0;
   logic       stop    = 1'b0;
   logic       loop_en = 1'b0;
   logic [1:0] tempo   = 2'b00;
   logic [7:0] rom_addr;
   logic [7:0] rom_note = 8'd0;
   logic [7:0] fullnote;
   logic       gate;
   logic       busy;
   logic       paused;
   logic       song_done;

   logic [7:0] rom_mem [4] = '{8'd25, 8'd0, 8'd27, 8'd30};

   int n_pass   = 0;
   int n_checks = 0;
   int cyc      = 0;

   // Model: mode 0 idle / 1 running / 2 paused; pos counts cycles into the
   // slot (0,1 fetch, 2.. playing with counter = pos-2).
   int         m_mode;
   int         m_addr;
   int         m_pos;
   int         m_len;
   int         m_gap;
   logic [7:0] m_note;
   bit         m_done;
   bit         m_resumed;

   song_sequencer #(
      .ADDR_W      (8),
      .LAST_ADDR   (LAST),
      .SLOT_CYCLES (SLOT),
      .GAP_CYCLES  (GAP)
   ) dut (
      .clk       (clk),
      .RESET     (RESET),
      .play      (play),
      .stop      (stop),
      .loop_en   (loop_en),
      .tempo     (tempo),
      .rom_addr  (rom_addr),
      .rom_note  (rom_note),
      .fullnote  (fullnote),
      .gate      (gate),
      .busy      (busy),
      .paused    (paused),
      .song_done (song_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rom_note <= rom_mem[rom_addr[1:0]];

   function automatic int len_of(input logic [1:0] t);
      if (t == 2'b01) return SLOT / 2;
      if (t == 2'b10) return SLOT * 2;
      return SLOT;
   endfunction

   function automatic int gap_of(input logic [1:0] t);
      if (t == 2'b01) return GAP / 2;
      if (t == 2'b10) return GAP * 2;
      return GAP;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_addr = 0; m_pos = 0; m_len = SLOT; m_gap = GAP;
      m_note = 8'd0; m_done = 0; m_resumed = 0;
   endtask

   task automatic model_edge();
      bit fresh;
      fresh  = 0;
      m_done = 0;
      if (RESET) begin
         model_reset();
         return;
      end
      if (stop) begin
         m_mode = 0; m_addr = 0; m_note = 8'd0;
      end else if (m_mode == 0) begin
         if (play) begin
            m_mode = 1; m_pos = 0; m_addr = 0;
         end
      end else if (m_mode == 1) begin
         if (m_pos < 2) begin
            if (m_pos == 1) begin
               m_len  = len_of(tempo);
               m_gap  = gap_of(tempo);
               m_note = rom_mem[m_addr];
            end
            m_pos++;
         end else if (play) begin
            m_mode = 2;
         end else if (m_pos - 2 == m_len - 1) begin
            if (m_addr != LAST) begin
               m_addr++; m_pos = 0;
            end else if (loop_en) begin
               m_addr = 0; m_pos = 0;
            end else begin
               m_mode = 0; m_done = 1; m_addr = 0; m_note = 8'd0;
            end
         end else begin
            m_pos++;
         end
      end else begin
         if (play) begin
            m_mode = 1; fresh = 1;
         end
      end
      m_resumed = fresh;
   endtask

   function automatic logic [19:0] exp_vec();
      logic g;
      g = (m_mode == 1) && (m_pos >= 2) && ((m_pos - 2) >= m_gap) && (m_note != 8'd0) && !m_resumed;
      return {8'(m_addr), m_note, g, (m_mode != 0), (m_mode == 2), m_done};
   endfunction

   function automatic logic [19:0] got_vec();
      return {rom_addr, fullnote, gate, busy, paused, song_done};
   endfunction

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      cyc++;
      play = 1'b0;
      stop = 1'b0;
   endtask

   task automatic test_reset();
      model_reset();
      for (int i = 0; i < 2; i++) begin
         step();
         if (got_vec() !== 20'h0) $display("FAIL reset_hold cyc=%0d got=%05h exp=00000", cyc, got_vec());
         else n_pass++;
         n_checks++;
      end
      RESET = 1'b0;
      step();
      if (got_vec() !== exp_vec()) $display("FAIL reset_release cyc=%0d got=%05h exp=%05h", cyc, got_vec(), exp_vec());
      else n_pass++;
      n_checks++;
   endtask

   task automatic test_play_tempos();
      for (int k = 0; k < 3; k++) begin
         int len, gp, n_done, n_hi, t1, t2;
         bit fin;
         tempo = 2'(k); loop_en = 1'b0;
         len = len_of(tempo); gp = gap_of(tempo);
         n_done = 0; n_hi = 0; t1 = -1; t2 = -1; fin = 0;
         repeat ($urandom_range(0, 4)) begin
            step();
            if (got_vec() !== exp_vec()) $display("FAIL tempo_idle cyc=%0d got=%05h exp=%05h", cyc, got_vec(), exp_vec());
            else n_pass++;
            n_checks++;
         end
         play = 1'b1;
         for (int i = 0; i < 200 && !fin; i++) begin
            step();
            if (got_vec() !== exp_vec()) $display("FAIL tempo_song cyc=%0d got=%05h exp=%05h", cyc, got_vec(), exp_vec());
            else n_pass++;
            n_checks++;
            if (gate) n_hi++;
            if (song_done) n_done++;
            if (rom_addr == 8'd1 && t1 < 0) t1 = cyc;
            if (rom_addr == 8'd2 && t2 < 0) t2 = cyc;
            if (m_done) fin = 1;
         end
         for (int i = 0; i < 3; i++) begin
            step();
            if (got_vec() !== exp_vec()) $display("FAIL tempo_after cyc=%0d got=%05h exp=%05h", cyc, got_vec(), exp_vec());
            else n_pass++;
            n_checks++;
            if (song_done) n_done++;
         end
         if (t2 - t1 !== len + 2) $display("FAIL tempo_period tempo=%0d got=%0d exp=%0d", k, t2 - t1, len + 2);
         else n_pass++;
         n_checks++;
         if (n_hi !== 3 * (len - gp)) $display("FAIL tempo_gate_cycles tempo=%0d got=%0d exp=%0d", k, n_hi, 3 * (len - gp));
         else n_pass++;
         n_checks++;
         if (n_done !== 1) $display("FAIL tempo_done_pulses tempo=%0d got=%0d exp=1", k, n_done);
         else n_pass++;
         n_checks++;
      end
   endtask

   task automatic test_tempo_toggle();
      loop_en = 1'($urandom_range(0, 1));
      tempo   = 2'($urandom_range(0, 3));
      play    = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 5) == 0) tempo = 2'($urandom_range(0, 3));
         if (m_mode == 0) play = 1'b1;
         step();
         if (got_vec() !== exp_vec()) $display("FAIL tempo_toggle cyc=%0d got=%05h exp=%05h", cyc, got_vec(), exp_vec());
         else n_pass++;
         n_checks++;
      end
      stop = 1'b1;
      step();
   endtask

   task automatic test_pause();
      int n_ok, n;
      tempo = 2'b00; loop_en = 1'b0;
      play = 1'b1;
      for (int i = 0; i < 100 && !(m_mode == 1 && m_addr == 2 && m_pos == 9); i++) begin
         step();
         if (got_vec() !== exp_vec()) $display("FAIL pause_lead cyc=%0d got=%05h exp=%05h", cyc, got_vec(), exp_vec());
         else n_pass++;
         n_checks++;
      end
      play = 1'b1;
      step();
      if (got_vec() !== exp_vec()) $display("FAIL pause_enter cyc=%0d got=%05h exp=%05h", cyc, got_vec(), exp_vec());
      else n_pass++;
      n_checks++;
      n_ok = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (got_vec() !== exp_vec()) $display("FAIL pause_wait cyc=%0d got=%05h exp=%05h", cyc, got_vec(), exp_vec());
         else n_pass++;
         n_checks++;
         if (paused === 1'b1 && gate === 1'b0 && fullnote === 8'd27) n_ok++;
      end
      if (n_ok !== 50) $display("FAIL pause_hold_cycles got=%0d exp=50", n_ok);
      else n_pass++;
      n_checks++;
      play = 1'b1;
      step();
      if (got_vec() !== exp_vec()) $display("FAIL pause_resume cyc=%0d got=%05h exp=%05h", cyc, got_vec(), exp_vec());
      else n_pass++;
      n_checks++;
      n = 0;
      while (n < 40 && rom_addr !== 8'd3) begin
         step();
         n++;
         if (got_vec() !== exp_vec()) $display("FAIL pause_tail cyc=%0d got=%05h exp=%05h", cyc, got_vec(), exp_vec());
         else n_pass++;
         n_checks++;
      end
      if (n !== 9) $display("FAIL pause_remaining_cycles got=%0d exp=9", n);
      else n_pass++;
      n_checks++;
      stop = 1'b1;
      step();
   endtask

   task automatic test_loop();
      int wraps, n_done;
      logic [7:0] prev;
      loop_en = 1'b1;
      tempo   = 2'($urandom_range(0, 3));
      wraps = 0; n_done = 0; prev = 8'd0;
      play = 1'b1;
      for (int i = 0; i < 500 && wraps < 3; i++) begin
         step();
         if (got_vec() !== exp_vec()) $display("FAIL loop_run cyc=%0d got=%05h exp=%05h", cyc, got_vec(), exp_vec());
         else n_pass++;
         n_checks++;
         if (song_done) n_done++;
         if (prev == 8'd3 && rom_addr == 8'd0) wraps++;
         prev = rom_addr;
      end
      if (wraps !== 3) $display("FAIL loop_wraps got=%0d exp=3", wraps);
      else n_pass++;
      n_checks++;
      if (n_done !== 0) $display("FAIL loop_done_pulses got=%0d exp=0", n_done);
      else n_pass++;
      n_checks++;
      step();
      step();
      if (fullnote !== 8'd25 || rom_addr !== 8'd0) $display("FAIL loop_first_note got=%0d@%0d exp=25@0", fullnote, rom_addr);
      else n_pass++;
      n_checks++;
      stop = 1'b1;
      step();
      if (got_vec() !== exp_vec()) $display("FAIL loop_stop cyc=%0d got=%05h exp=%05h", cyc, got_vec(), exp_vec());
      else n_pass++;
      n_checks++;
      loop_en = 1'b0;
   endtask

   task automatic test_stop();
      for (int r = 0; r < 4; r++) begin
         tempo   = 2'($urandom_range(0, 3));
         loop_en = 1'($urandom_range(0, 1));
         play = 1'b1;
         repeat ($urandom_range(4, 40)) begin
            step();
            if (got_vec() !== exp_vec()) $display("FAIL stop_lead cyc=%0d got=%05h exp=%05h", cyc, got_vec(), exp_vec());
            else n_pass++;
            n_checks++;
         end
         play = 1'b1;
         stop = 1'b1;
         step();
         if ({rom_addr, fullnote, gate, busy, song_done} !== 19'd0) $display("FAIL stop_with_play cyc=%0d got=%05h exp=00000", cyc, got_vec());
         else n_pass++;
         n_checks++;
         play = 1'b1;
         step();
         if (got_vec() !== exp_vec()) $display("FAIL stop_refetch cyc=%0d got=%05h exp=%05h", cyc, got_vec(), exp_vec());
         else n_pass++;
         n_checks++;
         stop = 1'b1;
         step();
         if ({rom_addr, fullnote, gate, busy, song_done} !== 19'd0) $display("FAIL stop_in_fetch cyc=%0d got=%05h exp=00000", cyc, got_vec());
         else n_pass++;
         n_checks++;
      end
   endtask

   task automatic test_reset_mid();
      tempo = 2'b00; loop_en = 1'b0;
      play = 1'b1;
      for (int i = 0; i < 100 && !(m_mode == 1 && m_addr == 2 && m_pos == 11); i++) begin
         step();
         if (got_vec() !== exp_vec()) $display("FAIL rst_lead cyc=%0d got=%05h exp=%05h", cyc, got_vec(), exp_vec());
         else n_pass++;
         n_checks++;
      end
      RESET = 1'b1;
      #1;
      if (got_vec() !== 20'h0) $display("FAIL rst_async got=%05h exp=00000", got_vec());
      else n_pass++;
      n_checks++;
      model_reset();
      step();
      RESET = 1'b0;
      step();
      if (got_vec() !== exp_vec()) $display("FAIL rst_release cyc=%0d got=%05h exp=%05h", cyc, got_vec(), exp_vec());
      else n_pass++;
      n_checks++;
      play = 1'b1;
      step();
      if (rom_addr !== 8'd0 || busy !== 1'b1) $display("FAIL rst_restart got=%0d/%0b exp=0/1", rom_addr, busy);
      else n_pass++;
      n_checks++;
      repeat (30) begin
         step();
         if (got_vec() !== exp_vec()) $display("FAIL rst_replay cyc=%0d got=%05h exp=%05h", cyc, got_vec(), exp_vec());
         else n_pass++;
         n_checks++;
      end
      stop = 1'b1;
      step();
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 39) == 0) play = 1'b1;
         if ($urandom_range(0, 149) == 0) stop = 1'b1;
         if ($urandom_range(0, 99) == 0) loop_en = ~loop_en;
         if ($urandom_range(0, 29) == 0) tempo = 2'($urandom_range(0, 3));
         step();
         if (got_vec() !== exp_vec()) $display("FAIL random cyc=%0d got=%05h exp=%05h", cyc, got_vec(), exp_vec());
         else n_pass++;
         n_checks++;
      end
   endtask

   initial begin
      test_reset();
      test_play_tempos();
      test_tempo_toggle();
      test_pause();
      test_loop();
      test_stop();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
